pic_ack_master: RTL and testbench
=================================

Name: pic_ack_master

Overview:
- CPU-side interrupt acknowledge engine that sits opposite the pic block on its register bus and acknowledge line.
- Watches the PIC interrupt output and issues the two-pulse intackN acknowledge sequence.
- Between the two pulses it reads ISR over the shared data/select/readwrite bus, decodes the in-service level and hands it to the host through a valid/ready handshake.
- Also performs host-requested IMR writes, so it is the only bus master the PIC sees.

Parameters:
- ACK_GAP, 8: clocks intackN is held high between the first ack pulse and the ISR read (1..255).
- HOLDOFF, 2: clocks spent in HOLDOFF after the second ack pulse before int_in is sampled again (1..255).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- int_in  input  1  interrupt request from pic int_out.
- data  inout  8  PIC register data bus; driven only in WR_IMR, otherwise 8'hzz.
- select  output  2  register select (SEL_OCR/SEL_IMR/SEL_IRR/SEL_ISR from pic.vh).
- readwrite  output  1  RW_READ/RW_WRITE from pic.vh.
- intackN  output  1  active-low interrupt acknowledge to the PIC.
- enable  input  1  when 0, new interrupts are not serviced; a sequence already started still completes.
- imr_wr_valid  input  1  host request to write IMR.
- imr_wr_data  input  8  IMR value to write.
- imr_wr_ready  output  1  high only in IDLE; a write is accepted when valid&ready.
- irq_valid  output  1  decoded interrupt available.
- irq_ready  input  1  host consumes the decoded interrupt.
- irq_num  output  3  index of the lowest set bit of the captured ISR.
- irq_isr  output  8  raw captured ISR value.
- irq_spurious  output  1  captured ISR was 8'h00; irq_num = 0.
- busy  output  1  state != IDLE.
- svc_count  output  8  count of completed acknowledge sequences; wraps 8'hff -> 8'h00.

Behaviour:
- All outputs are registered.
- Reset (asynchronous) puts the block in IDLE with:
  - intackN=1, select=SEL_OCR, readwrite=RW_READ, data=z
  - irq_valid=0, irq_num=0, irq_isr=8'h00, irq_spurious=0, busy=0, svc_count=0
- Reset asserted mid-sequence forces intackN high immediately and abandons the sequence; no partial IMR write is retried.
- Idle bus state: select=SEL_OCR, readwrite=RW_READ, data=z.
- States: IDLE, WR_IMR, ACK1, GAP1, RD_ISR, REPORT, ACK2, HOLDOFF.
- IDLE transitions:
  - imr_wr_valid=1 -> WR_IMR; this has priority over int_in.
  - Else if int_in=1 and enable=1 -> ACK1.
- WR_IMR: exactly 1 clock with select=SEL_IMR, readwrite=RW_WRITE, data=imr_wr_data (latched at accept); then IDLE.
- ACK1: intackN=0 for exactly 1 clock.
  - intackN falls on the edge after int_in is sampled high in IDLE (1-clock latency).
- GAP1: intackN=1 for ACK_GAP clocks, timed by a down-counter loaded on entry.
- RD_ISR: 1 clock with select=SEL_ISR, readwrite=RW_READ, data=z.
  - data is captured into irq_isr on the edge that leaves RD_ISR.
  - irq_num and irq_spurious are computed from the captured value on that same edge.
- REPORT: irq_valid=1, holding irq_num/irq_isr/irq_spurious stable until irq_ready=1.
  - On that edge irq_valid drops and the state goes to ACK2.
  - irq_ready while irq_valid=0 is ignored.
- ACK2: intackN=0 for exactly 1 clock; svc_count increments on exit.
- HOLDOFF: intackN=1 for HOLDOFF clocks; then IDLE.
  - A still-high or re-asserted int_in after HOLDOFF starts a new sequence; pending interrupts are serviced back-to-back, one level per sequence.
- int_in dropping after ACK1 does not abort the sequence.
- data is never driven while readwrite=RW_READ.
- Minimum sequence length: 1 (IDLE sample) + 1 + ACK_GAP + 1 + 1 (REPORT with irq_ready=1) + 1 + HOLDOFF clocks.
- enable=0 in IDLE with int_in=1: stays in IDLE, and IMR writes are still accepted.

Test Plan:
- Reset then idle, int_in=0 for 10 clocks:
  - outputs stay at reset values, data=z, select=SEL_OCR, readwrite=RW_READ.
- imr_wr_valid=1, imr_wr_data=8'haa:
  - one clock with select=SEL_IMR, readwrite=RW_WRITE, data=8'haa, then the idle bus.
  - A subsequent pic readback of IMR returns 8'haa.
- PIC intreq=8'h04 with irq_ready tied high:
  - intackN low 1 clock, high 8 clocks, then ISR read.
  - irq_valid pulses with irq_isr=8'h04, irq_num=2, irq_spurious=0.
  - Second intackN pulse follows; int_in falls; svc_count=1.
- intreq=8'h05, then drop to 8'h04 after the first REPORT:
  - first sequence irq_num=0, second sequence irq_num=2.
  - svc_count=2; intackN pulses are separated by at least HOLDOFF clocks.
- irq_ready held low 20 clocks in REPORT:
  - irq_valid and irq_num remain stable and intackN stays high.
  - irq_ready=1 -> ACK2 on the next clock.
- resetN pulsed low during GAP1:
  - all outputs return to reset values asynchronously.
  - With int_in still high after release, a fresh sequence starts with ACK1.
- imr_wr_valid and int_in rise in the same clock:
  - WR_IMR occurs first, then ACK1 on the following IDLE cycle.

Source files
------------

// File: rtl/pic_ack_master.sv
// CPU-side interrupt acknowledge engine: issues the two-pulse intackN sequence, reads ISR
// between the pulses, reports the decoded level to the host and performs host IMR writes.
module pic_ack_master #(
    parameter int unsigned ACK_GAP = 8,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       int_in,
    inout  wire  [7:0] data,
    output logic [1:0] select,
    output logic       readwrite,
    output logic       intackN,
    input  logic       enable,
    input  logic       imr_wr_valid,
    input  logic [7:0] imr_wr_data,
    output logic       imr_wr_ready,
    output logic       irq_valid,
    input  logic       irq_ready,
    output logic [2:0] irq_num,
    output logic [7:0] irq_isr,
    output logic       irq_spurious,
    output logic       busy,
    output logic [7:0] svc_count
);

    // Register-bus encoding shared with the pic block.
    localparam logic [1:0] SEL_OCR  = 2'd0;
    localparam logic [1:0] SEL_IMR  = 2'd1;
    localparam logic [1:0] SEL_ISR  = 2'd3;
    localparam logic       RW_READ  = 1'b0;
    localparam logic       RW_WRITE = 1'b1;

    // Counters are loaded with N-1 so that the state lasts exactly N clocks.
    localparam logic [7:0] GAP_LOAD  = 8'(ACK_GAP - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrImr,
        StAck1,
        StGap1,
        StRdIsr,
        StReport,
        StAck2,
        StHoldoff
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       drive_en;
    logic [7:0] wr_data;

    assign data = drive_en ? wr_data : 8'hzz;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= StIdle;
            cnt          <= 8'd0;
            intackN      <= 1'b1;
            select       <= SEL_OCR;
            readwrite    <= RW_READ;
            drive_en     <= 1'b0;
            wr_data      <= 8'h00;
            imr_wr_ready <= 1'b1;
            irq_valid    <= 1'b0;
            irq_num      <= 3'd0;
            irq_isr      <= 8'h00;
            irq_spurious <= 1'b0;
            busy         <= 1'b0;
            svc_count    <= 8'h00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (imr_wr_valid) begin
                        state        <= StWrImr;
                        select       <= SEL_IMR;
                        readwrite    <= RW_WRITE;
                        drive_en     <= 1'b1;
                        wr_data      <= imr_wr_data;
                        imr_wr_ready <= 1'b0;
                        busy         <= 1'b1;
                    end else if (int_in && enable) begin
                        state        <= StAck1;
                        intackN      <= 1'b0;
                        imr_wr_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                StWrImr: begin
                    state        <= StIdle;
                    select       <= SEL_OCR;
                    readwrite    <= RW_READ;
                    drive_en     <= 1'b0;
                    imr_wr_ready <= 1'b1;
                    busy         <= 1'b0;
                end
                StAck1: begin
                    state   <= StGap1;
                    intackN <= 1'b1;
                    cnt     <= GAP_LOAD;
                end
                StGap1: begin
                    if (cnt == 8'd0) begin
                        state  <= StRdIsr;
                        select <= SEL_ISR;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StRdIsr: begin
                    // The PIC drives ISR while select/readwrite address it; capture on exit.
                    state        <= StReport;
                    select       <= SEL_OCR;
                    irq_isr      <= data;
                    irq_num      <= lowest_set(data);
                    irq_spurious <= (data == 8'h00);
                    irq_valid    <= 1'b1;
                end
                StReport: begin
                    if (irq_ready) begin
                        state     <= StAck2;
                        irq_valid <= 1'b0;
                        intackN   <= 1'b0;
                    end
                end
                StAck2: begin
                    state     <= StHoldoff;
                    intackN   <= 1'b1;
                    svc_count <= svc_count + 8'd1;
                    cnt       <= HOLD_LOAD;
                end
                StHoldoff: begin
                    if (cnt == 8'd0) begin
                        state        <= StIdle;
                        busy         <= 1'b0;
                        imr_wr_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ack_master.sv
// Scoreboard bench for pic_ack_master with a behavioural PIC model on the far side of the bus.
module tb_pic_ack_master;

    localparam int unsigned ACK_GAP = 8;
    localparam int unsigned HOLDOFF = 2;
    localparam logic [1:0] SEL_OCR  = 2'd0;
    localparam logic [1:0] SEL_IMR  = 2'd1;
    localparam logic [1:0] SEL_ISR  = 2'd3;
    localparam logic       RW_READ  = 1'b0;
    localparam logic       RW_WRITE = 1'b1;
    localparam logic [7:0] BUS_IDLE = 8'h5a;

    typedef struct packed {
        logic [7:0] isr;
        logic [2:0] num;
        logic       spur;
    } irq_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       int_in;
    wire  [7:0] data;
    logic [1:0] select;
    logic       readwrite;
    logic       intackN;
    logic       enable = 1'b1;
    logic       imr_wr_valid = 1'b0;
    logic [7:0] imr_wr_data = 8'h00;
    logic       imr_wr_ready;
    logic       irq_valid;
    logic       irq_ready = 1'b1;
    logic [2:0] irq_num;
    logic [7:0] irq_isr;
    logic       irq_spurious;
    logic       busy;
    logic [7:0] svc_count;

    int checks = 0;
    int errors = 0;

    // PIC model state
    logic [7:0] intreq = 8'h00;
    logic [7:0] intreq_q = 8'h00;
    logic [7:0] irr = 8'h00;
    logic [7:0] isr_m = 8'h00;
    logic [7:0] imr_m = 8'h00;
    logic       in_seq = 1'b0;
    logic       ack_n_q = 1'b1;
    logic       spur_line = 1'b0;
    irq_t       pic_next;

    irq_t       exp_q[$];
    logic [7:0] imr_q[$];

    pic_ack_master #(
        .ACK_GAP(ACK_GAP),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .int_in      (int_in),
        .data        (data),
        .select      (select),
        .readwrite   (readwrite),
        .intackN     (intackN),
        .enable      (enable),
        .imr_wr_valid(imr_wr_valid),
        .imr_wr_data (imr_wr_data),
        .imr_wr_ready(imr_wr_ready),
        .irq_valid   (irq_valid),
        .irq_ready   (irq_ready),
        .irq_num     (irq_num),
        .irq_isr     (irq_isr),
        .irq_spurious(irq_spurious),
        .busy        (busy),
        .svc_count   (svc_count)
    );

    always #5 clk = ~clk;

    // Lowest pending level wins; nothing pending at acknowledge time means spurious.
    function automatic irq_t model_irq(input logic [7:0] pend);
        irq_t r;
        logic [7:0] oh;
        oh     = pend & (~pend + 8'd1);
        r.isr  = oh;
        r.num  = (oh == 8'h00) ? 3'd0 : 3'($clog2(oh));
        r.spur = (oh == 8'h00);
        return r;
    endfunction

    task automatic chk(input string name, input bit ok, input logic [31:0] got,
                       input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    // The far side answers every read: ISR when addressed, a fixed pattern otherwise,
    // so a master that drives during a read corrupts what is seen on the bus.
    assign data     = (readwrite == RW_READ) ? ((select == SEL_ISR) ? isr_m : BUS_IDLE) : 8'hzz;
    assign int_in   = !in_seq && ((|(irr & ~imr_m)) || spur_line);
    assign pic_next = model_irq(irr & ~imr_m);

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            irr     <= irr | isr_m;
            isr_m   <= 8'h00;
            in_seq  <= 1'b0;
            ack_n_q <= 1'b1;
            exp_q.delete();
        end else begin
            ack_n_q  <= intackN;
            intreq_q <= intreq;
            if (select == SEL_IMR && readwrite == RW_WRITE) imr_m <= data;
            if (ack_n_q && !intackN && !in_seq) begin
                exp_q.push_back(pic_next);
                isr_m  <= pic_next.isr;
                in_seq <= 1'b1;
                irr    <= (irr & ~pic_next.isr) | (intreq & ~intreq_q);
            end else begin
                if (ack_n_q && !intackN) begin
                    isr_m  <= 8'h00;
                    in_seq <= 1'b0;
                end
                irr <= irr | (intreq & ~intreq_q);
            end
        end
    end

    // Monitor
    int   cyc = 0;
    int   t_ack1 = 0;
    int   t_ack2 = -1000;
    int   exp_svc = 0;
    logic mon_in_seq = 1'b0;
    logic prev_ack_n = 1'b1;
    logic hold_pend = 1'b0;
    irq_t held;
    irq_t mon_e;
    logic [7:0] mon_imr;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!resetN) begin
            mon_in_seq = 1'b0;
            prev_ack_n = 1'b1;
            hold_pend  = 1'b0;
            exp_svc    = 0;
            t_ack2     = -1000;
        end else begin
            if (hold_pend)
                chk("irq_hold", irq_valid && ({irq_isr, irq_num, irq_spurious} == held),
                    {19'd0, irq_valid, irq_isr, irq_num, irq_spurious}, {20'd1, held});
            hold_pend = irq_valid && !irq_ready;
            held      = {irq_isr, irq_num, irq_spurious};
            if (irq_valid && irq_ready) begin
                if (exp_q.size() == 0) begin
                    chk("irq_unexpected", 1'b0, {20'd0, irq_isr, irq_num, irq_spurious}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("irq", {irq_isr, irq_num, irq_spurious} == mon_e,
                        {20'd0, irq_isr, irq_num, irq_spurious}, {20'd0, mon_e});
                end
            end
            if (select == SEL_IMR && readwrite == RW_WRITE) begin
                if (imr_q.size() == 0) begin
                    chk("imr_unexpected", 1'b0, {24'd0, data}, 0);
                end else begin
                    mon_imr = imr_q.pop_front();
                    chk("imr_data", data == mon_imr, {24'd0, data}, {24'd0, mon_imr});
                end
            end
            if (readwrite == RW_READ && select != SEL_ISR)
                chk("bus_idle", data == BUS_IDLE, {24'd0, data}, {24'd0, BUS_IDLE});
            if (!intackN) begin
                chk("ack_width", prev_ack_n, 0, 1);
                if (!mon_in_seq) begin
                    chk("holdoff", (cyc - t_ack2) >= int'(HOLDOFF) + 2, cyc - t_ack2,
                        int'(HOLDOFF) + 2);
                    t_ack1     = cyc;
                    mon_in_seq = 1'b1;
                end else begin
                    t_ack2     = cyc;
                    mon_in_seq = 1'b0;
                    exp_svc++;
                end
            end else begin
                chk("svc_count", svc_count == 8'(exp_svc), {24'd0, svc_count}, exp_svc);
            end
            if (select == SEL_ISR)
                chk("ack_gap", (cyc - t_ack1) == int'(ACK_GAP) + 1, cyc - t_ack1,
                    int'(ACK_GAP) + 1);
            prev_ack_n = intackN;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_intackN"}, intackN == 1'b1, {31'd0, intackN}, 1);
        chk({tag, "_select"}, select == SEL_OCR, {30'd0, select}, {30'd0, SEL_OCR});
        chk({tag, "_readwrite"}, readwrite == RW_READ, {31'd0, readwrite}, {31'd0, RW_READ});
        chk({tag, "_data"}, data == BUS_IDLE, {24'd0, data}, {24'd0, BUS_IDLE});
        chk({tag, "_irq_valid"}, irq_valid == 1'b0, {31'd0, irq_valid}, 0);
        chk({tag, "_irq_fields"}, {irq_isr, irq_num, irq_spurious} == 12'h000,
            {20'd0, irq_isr, irq_num, irq_spurious}, 0);
        chk({tag, "_busy"}, busy == 1'b0, {31'd0, busy}, 0);
        chk({tag, "_svc_count"}, svc_count == 8'h00, {24'd0, svc_count}, 0);
        chk({tag, "_imr_wr_ready"}, imr_wr_ready == 1'b1, {31'd0, imr_wr_ready}, 1);
    endtask

    task automatic imr_write(input logic [7:0] d);
        bit acc;
        acc          = 1'b0;
        imr_wr_valid = 1'b1;
        imr_wr_data  = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(posedge clk);
            acc = imr_wr_ready;
            #2;
        end
        imr_wr_valid = 1'b0;
        if (acc) imr_q.push_back(d);
        chk("imr_accept", acc, {31'd0, acc}, 1);
    endtask

    task automatic wait_svc(input int target);
        bit hit;
        hit = (svc_count == 8'(target));
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            hit = (svc_count == 8'(target));
        end
        chk("svc_reach", hit, {24'd0, svc_count}, target);
    endtask

    task automatic wait_idle();
        bit hit;
        hit = !busy;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            hit = !busy;
        end
        chk("idle_reach", hit, {31'd0, busy}, 0);
    endtask

    task automatic wait_ack_low(input string name);
        bit hit;
        hit = !intackN;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = !intackN;
        end
        chk(name, hit, {31'd0, intackN}, 0);
    endtask

    initial begin
        bit acc;
        bit hit;

        @(posedge clk);
        #1;
        check_reset_vals("reset");
        tick();
        tick();
        resetN = 1'b1;
        repeat (10) tick();
        check_reset_vals("idle");

        imr_write(8'haa);
        repeat (3) tick();
        chk("imr_readback", imr_m == 8'haa, {24'd0, imr_m}, 32'haa);
        imr_write(8'h00);
        repeat (3) tick();

        irq_ready = 1'b1;
        intreq    = 8'h04;
        wait_svc(1);
        intreq = 8'h00;
        tick();

        intreq = 8'h05;
        hit    = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = irq_valid;
        end
        intreq = 8'h04;
        wait_svc(3);
        intreq = 8'h00;
        wait_idle();

        irq_ready = 1'b0;
        intreq    = 8'h08;
        hit       = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = irq_valid;
        end
        chk("report_reach", hit, {31'd0, hit}, 1);
        repeat (20) begin
            tick();
            chk("report_stall", intackN && irq_valid && irq_num == 3'd3,
                {27'd0, intackN, irq_valid, irq_num}, {27'd0, 2'b11, 3'd3});
        end
        irq_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ack2_next", intackN == 1'b0, {31'd0, intackN}, 0);
        #1;
        wait_svc(4);
        intreq = 8'h00;
        wait_idle();

        intreq = 8'h10;
        wait_ack_low("mid_ack1");
        repeat (3) tick();
        #1;
        resetN = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #3;
        resetN = 1'b1;
        wait_ack_low("restart_ack1");
        wait_svc(1);
        intreq = 8'h00;
        wait_idle();

        intreq = 8'h20;
        tick();
        chk("same_clk_ready", imr_wr_ready && int_in, {30'd0, imr_wr_ready, int_in}, 3);
        imr_wr_valid = 1'b1;
        imr_wr_data  = 8'h00;
        imr_q.push_back(8'h00);
        @(posedge clk);
        #1;
        chk("wr_first", select == SEL_IMR && intackN, {29'd0, select, intackN},
            {29'd0, SEL_IMR, 1'b1});
        #1;
        imr_wr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_between", select == SEL_OCR && intackN, {29'd0, select, intackN},
            {29'd0, SEL_OCR, 1'b1});
        @(posedge clk);
        #1;
        chk("ack1_after_wr", intackN == 1'b0, {31'd0, intackN}, 0);
        #1;
        wait_svc(2);
        intreq = 8'h00;
        wait_idle();

        enable = 1'b0;
        intreq = 8'h40;
        repeat (10) tick();
        chk("enable_off", !busy && intackN && int_in, {29'd0, busy, intackN, int_in}, 3);
        imr_write(8'h00);
        enable = 1'b1;
        wait_svc(3);
        intreq = 8'h00;
        wait_idle();

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            acc = imr_wr_valid && imr_wr_ready;
            #2;
            if (acc) begin
                imr_q.push_back(imr_wr_data);
                imr_wr_valid = 1'b0;
            end else if (!imr_wr_valid && $urandom_range(0, 99) < 2) begin
                imr_wr_valid = 1'b1;
                imr_wr_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
            irq_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 5) intreq = 8'($urandom);
            spur_line = ($urandom_range(0, 99) < 3);
            enable    = ($urandom_range(0, 99) < 90);
        end

        spur_line = 1'b0;
        enable    = 1'b1;
        irq_ready = 1'b1;
        intreq    = 8'h00;
        for (int i = 0; i < 100 && imr_wr_valid; i++) begin
            @(posedge clk);
            acc = imr_wr_ready;
            #2;
            if (acc) begin
                imr_q.push_back(imr_wr_data);
                imr_wr_valid = 1'b0;
            end
        end
        imr_write(8'h00);
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            tick();
            hit = (irr == 8'h00) && !busy && !in_seq && (exp_q.size() == 0);
        end
        chk("drain", hit, {24'd0, irr}, 0);
        chk("irq_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
        chk("imr_queue_empty", imr_q.size() == 0, imr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
